fir_shift_accumulator: RTL and testbench

//  Downstream stage of i_shifter in the FIR datapath. Sums the power-of-two-scaled terms that
//  i_shifter produces, one term per cycle, into a signed accumulator.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_saturate.sv | 30 +++
 rtl/fir_shift_accumulator.sv | 98 +++++++++
 tb/tb_fir_shift_accumulator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR shift-accumulator datapath.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic signed [63:0] sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  function automatic int unsigned acc_width_min(input int unsigned width, input int unsigned taps);
    return width + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_saturate.sv
// Combinational clamp of a wide signed sum into a narrower signed range; flags when clamping occurred.
module fir_saturate
  import fir_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH = 21
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat
);

  localparam logic signed [63:0] MAX64 = sat_max(OUT_WIDTH);
  localparam logic signed [63:0] MIN64 = sat_min(OUT_WIDTH);
  localparam logic signed [IN_WIDTH-1:0] MAX_V = MAX64[IN_WIDTH-1:0];
  localparam logic signed [IN_WIDTH-1:0] MIN_V = MIN64[IN_WIDTH-1:0];

  always_comb begin
    dout = din[OUT_WIDTH-1:0];
    sat  = 1'b0;
    if (din > MAX_V) begin
      dout = MAX_V[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_shift_accumulator.sv
// Accumulates signed shifted terms per sample and emits the saturated sum on a valid/ready output.
// Result registered one cycle after the closing term; input stalls (in_ready=0) while the result is held.
module fir_shift_accumulator
  import fir_pkg::*;
#(
  parameter int unsigned OUT_DATA_WIDTH = 21,
  parameter int unsigned NUM_TAPS       = 8,
  parameter int unsigned ACC_WIDTH      = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             select_line_vld,
  input  logic signed [OUT_DATA_WIDTH-1:0] in_data,
  input  logic                             sub_en,
  input  logic                             last_term,
  output logic                             in_ready,
  output logic signed [OUT_DATA_WIDTH-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             sat,
  output logic                             len_err
);

  localparam int unsigned CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic [CNT_W-1:0] TAPS_CNT = CNT_W'(NUM_TAPS);

  state_t                        state;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [CNT_W-1:0]              term_cnt;

  logic                          accept;
  logic signed [ACC_WIDTH-1:0]   term_ext;
  logic signed [ACC_WIDTH-1:0]   term;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]              cnt_next;
  logic                          cnt_full;
  logic                          closes;
  logic signed [OUT_DATA_WIDTH-1:0] sat_data;
  logic                          sat_flag;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = select_line_vld & in_ready;

  assign term_ext = {{(ACC_WIDTH - OUT_DATA_WIDTH){in_data[OUT_DATA_WIDTH-1]}}, in_data};
  assign term     = sub_en ? -term_ext : term_ext;

  // A term arriving in IDLE starts a fresh sample rather than adding to the last sum.
  assign acc_next = (state == IDLE) ? term : acc + term;
  assign cnt_next = (state == IDLE) ? CNT_W'(1) : term_cnt + CNT_W'(1);
  assign cnt_full = (cnt_next == TAPS_CNT);
  assign closes   = last_term | cnt_full;

  fir_saturate #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (OUT_DATA_WIDTH)
  ) u_sat (
    .din  (acc_next),
    .dout (sat_data),
    .sat  (sat_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      term_cnt <= '0;
      out_data <= '0;
      sat      <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc      <= acc_next;
            term_cnt <= cnt_next;
            if (closes) begin
              out_data <= sat_data;
              sat      <= sat_flag;
              len_err  <= cnt_full & ~last_term;
              state    <= HOLD;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_shift_accumulator.sv
// Directed bench for fir_shift_accumulator with hand-computed expectations.
module tb_fir_shift_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               select_line_vld;
  logic signed [20:0] in_data;
  logic               sub_en;
  logic               last_term;
  logic               in_ready;
  logic signed [20:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sat;
  logic               len_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_shift_accumulator #(
    .OUT_DATA_WIDTH (21),
    .NUM_TAPS       (8),
    .ACC_WIDTH      (24)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .select_line_vld (select_line_vld),
    .in_data         (in_data),
    .sub_en          (sub_en),
    .last_term       (last_term),
    .in_ready        (in_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .sat             (sat),
    .len_err         (len_err)
  );

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int d, input bit sub, input bit last);
    logic [31:0] dv;
    dv = d;
    select_line_vld = 1'b1;
    in_data         = dv[20:0];
    sub_en          = sub;
    last_term       = last;
    cyc();
    select_line_vld = 1'b0;
    sub_en          = 1'b0;
    last_term       = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int data, input int s);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"}, int'(out_data), data);
    chk({tag, "_sat"}, int'(sat), s);
    chk({tag, "_ready"}, int'(in_ready), 0);
  endtask

  initial begin
    rst = 1'b1;
    select_line_vld = 1'b0;
    in_data = '0;
    sub_en = 1'b0;
    last_term = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_len_err", int'(len_err), 0);
    chk("rst_ready", int'(in_ready), 1);

    // 1: simple three-term sum
    put(100, 0, 0);
    put(200, 0, 0);
    chk("t1_mid_valid", int'(out_valid), 0);
    put(50, 0, 1);
    chk_out("t1", 350, 0);
    chk("t1_len_err", int'(len_err), 0);
    cyc();
    chk("t1_drop_valid", int'(out_valid), 0);
    chk("t1_drop_ready", int'(in_ready), 1);

    // 2: subtraction, then fresh sample does not carry the old sum
    put(1000, 0, 0);
    put(300, 1, 1);
    chk_out("t2a", 700, 0);
    cyc();
    put(-5, 0, 1);
    chk_out("t2b", -5, 0);
    cyc();

    // 3: positive and negative saturation
    repeat (3) put(1048575, 0, 0);
    put(1048575, 0, 1);
    chk_out("t3p", 1048575, 1);
    cyc();
    repeat (3) put(-1048576, 0, 0);
    put(-1048576, 0, 1);
    chk_out("t3n", -1048576, 1);
    cyc();

    // 4: backpressure holds output and stalls input
    out_ready = 1'b0;
    put(10, 0, 1);
    chk_out("t4", 10, 0);
    select_line_vld = 1'b1;
    in_data = 21'sd7;
    last_term = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_out("t4_hold", 10, 0);
    end
    out_ready = 1'b1;
    cyc();
    chk("t4_release_valid", int'(out_valid), 0);
    chk("t4_release_ready", int'(in_ready), 1);
    cyc();
    select_line_vld = 1'b0;
    last_term = 1'b0;
    chk_out("t4_seven", 7, 0);
    cyc();

    // 5: eight terms without last_term force closure and pulse len_err
    repeat (7) put(1, 0, 0);
    chk("t5_seven_valid", int'(out_valid), 0);
    chk("t5_seven_len_err", int'(len_err), 0);
    put(1, 0, 0);
    chk_out("t5", 8, 0);
    chk("t5_len_err", int'(len_err), 1);
    cyc();
    chk("t5_len_err_drop", int'(len_err), 0);
    chk("t5_drop_valid", int'(out_valid), 0);
    put(1, 0, 0);
    chk("t5_ninth_valid", int'(out_valid), 0);
    chk("t5_ninth_ready", int'(in_ready), 1);
    put(2, 0, 1);
    chk_out("t5_new", 3, 0);
    cyc();

    // 6: reset mid-sample discards partial sum
    put(5, 0, 0);
    put(6, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_data", int'(out_data), 0);
    chk("t6_sat", int'(sat), 0);
    chk("t6_len_err", int'(len_err), 0);
    chk("t6_ready", int'(in_ready), 1);
    cyc();
    chk("t6_idle_valid", int'(out_valid), 0);
    put(10, 0, 1);
    chk_out("t6_after", 10, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
